// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter in front of a single 64-bit ALU with one registered, tagged result slot.

module alu_core (
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y,
  output logic        err
);
  always_comb begin
    y = '0;
    err = 1'b0;
    case (op)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a << b[5:0];
      4'd3: y = {63'd0, a < b};
      4'd4: y = a ^ b;
      4'd5: y = a >> b[5:0];
      4'd6: y = $unsigned($signed(a) >>> b[5:0]);
      4'd7: y = a | b;
      4'd8: y = a & b;
      default: err = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_b1,
  output logic        resp_valid0,
  output logic        resp_valid1,
  input  logic        resp_ready0,
  input  logic        resp_ready1,
  output logic [63:0] resp_result,
  output logic        resp_err,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic tag_q, tag_d, last_q, last_d, err_q, err_d;
  logic [63:0] result_q, result_d;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic slot_free, gnt1, accept, alu_err;
  logic [3:0] alu_op;
  logic [63:0] alu_a, alu_b, alu_y;

  alu_core u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y), .err(alu_err));

  always_comb begin
    slot_free = (state_q == IDLE) || (tag_q ? resp_ready1 : resp_ready0);
    // on a tie, round-robin favours the port that lost last time
    gnt1 = (req_valid0 && req_valid1) ? (RR_EN && !last_q) : req_valid1;
    accept = slot_free && (req_valid0 || req_valid1) && !rst;
    req_ready0 = accept && !gnt1;
    req_ready1 = accept && gnt1;
    alu_op = gnt1 ? req_op1 : req_op0;
    alu_a = gnt1 ? req_a1 : req_a0;
    alu_b = gnt1 ? req_b1 : req_b0;
    state_d = accept ? HOLD : (slot_free ? IDLE : state_q);
    tag_d = accept ? gnt1 : tag_q;
    last_d = accept ? gnt1 : last_q;
    result_d = accept ? alu_y : result_q;
    err_d = accept ? alu_err : err_q;
    cnt0_d = (req_ready0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = (req_ready1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q <= 1'b0;
      last_q <= 1'b1;
      result_q <= '0;
      err_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      last_q <= last_d;
      result_q <= result_d;
      err_q <= err_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign resp_valid0 = (state_q == HOLD) && !tag_q;
  assign resp_valid1 = (state_q == HOLD) && tag_q;
  assign resp_result = result_q;
  assign resp_err = err_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for a round-robin and a fixed-priority arbiter sharing one stimulus.

module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [3:0] op0 = 0, op1 = 0;
  logic [63:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic r_rdy0, r_rdy1, r_rv0, r_rv1, r_err;
  logic f_rdy0, f_rdy1, f_rv0, f_rv1, f_err;
  logic [63:0] r_res, f_res;
  logic [15:0] r_c0, r_c1, f_c0, f_c1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_valid0(v0), .req_valid1(v1), .req_ready0(r_rdy0), .req_ready1(r_rdy1),
    .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .resp_valid0(r_rv0), .resp_valid1(r_rv1), .resp_ready0(rr0), .resp_ready1(rr1),
    .resp_result(r_res), .resp_err(r_err), .grant_cnt0(r_c0), .grant_cnt1(r_c1));

  alu_arbiter #(.RR_EN(1'b0)) u_fx (
    .clk(clk), .rst(rst), .req_valid0(v0), .req_valid1(v1), .req_ready0(f_rdy0), .req_ready1(f_rdy1),
    .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .resp_valid0(f_rv0), .resp_valid1(f_rv1), .resp_ready0(rr0), .resp_ready1(rr1),
    .resp_result(f_res), .resp_err(f_err), .grant_cnt0(f_c0), .grant_cnt1(f_c1));

  typedef struct {
    logic p;
    logic [3:0] op;
    logic [63:0] a, b, y;
    logic e;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b0, 4'd0, 64'd5, 64'd7, 64'd12, 1'b0};
    tv[1]  = '{1'b1, 4'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tv[2]  = '{1'b0, 4'd2, 64'd1, 64'h41, 64'd2, 1'b0};
    tv[3]  = '{1'b1, 4'd3, 64'd3, 64'd5, 64'd1, 1'b0};
    tv[4]  = '{1'b0, 4'd3, 64'd5, 64'd3, 64'd0, 1'b0};
    tv[5]  = '{1'b1, 4'd4, 64'hF0, 64'hFF, 64'h0F, 1'b0};
    tv[6]  = '{1'b0, 4'd5, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0};
    tv[7]  = '{1'b1, 4'd6, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0};
    tv[8]  = '{1'b0, 4'd7, 64'hA0, 64'h0B, 64'hAB, 1'b0};
    tv[9]  = '{1'b1, 4'd8, 64'hFF, 64'h0F, 64'h0F, 1'b0};
    tv[10] = '{1'b0, 4'hC, 64'd5, 64'd7, 64'd0, 1'b1};
    tv[11] = '{1'b1, 4'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tv[12] = '{1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
    tv[13] = '{1'b1, 4'hF, 64'd3, 64'd3, 64'd0, 1'b1};

    // reset state, with a request pending to show it is held off
    v0 = 1;
    #2;
    chk("rst_req_ready0", r_rdy0, 0);
    tick();
    chk("rst_resp_valid0", r_rv0, 0);
    chk("rst_resp_valid1", r_rv1, 0);
    chk("rst_result", r_res, 0);
    chk("rst_err", r_err, 0);
    chk("rst_cnt0", r_c0, 0);
    chk("rst_cnt1", r_c1, 0);
    rst = 0;
    v0 = 0;
    tick();

    // single-requester ALU vectors, results drained every cycle
    rr0 = 1;
    rr1 = 1;
    for (int i = 0; i < 14; i++) begin
      v0 = !tv[i].p;
      v1 = tv[i].p;
      op0 = tv[i].op; a0 = tv[i].a; b0 = tv[i].b;
      op1 = tv[i].op; a1 = tv[i].a; b1 = tv[i].b;
      #2;
      chk($sformatf("v%0d_req_ready", i), tv[i].p ? r_rdy1 : r_rdy0, 1);
      chk($sformatf("v%0d_req_ready_other", i), tv[i].p ? r_rdy0 : r_rdy1, 0);
      tick();
      chk($sformatf("v%0d_resp_valid", i), {tv[i].p ? r_rv1 : r_rv0, tv[i].p ? r_rv0 : r_rv1}, 2'b10);
      chk($sformatf("v%0d_result", i), r_res, tv[i].y);
      chk($sformatf("v%0d_err", i), r_err, tv[i].e);
      chk($sformatf("v%0d_fx_result", i), f_res, tv[i].y);
    end
    v0 = 0;
    v1 = 0;
    tick();
    chk("tbl_resp_idle", {r_rv0, r_rv1}, 0);
    chk("tbl_cnt0", r_c0, 7);
    chk("tbl_cnt1", r_c1, 7);
    chk("tbl_fx_cnt0", f_c0, 7);
    chk("tbl_fx_cnt1", f_c1, 7);

    // continuous tie: round-robin alternates from port 0, fixed always port 0
    rst = 1;
    tick();
    rst = 0;
    v0 = 1;
    v1 = 1;
    op0 = 0; a0 = 1; b0 = 1;
    op1 = 0; a1 = 2; b1 = 2;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("rr%0d_ready0", i), r_rdy0, (i % 2) == 0);
      chk($sformatf("rr%0d_ready1", i), r_rdy1, (i % 2) == 1);
      chk($sformatf("fx%0d_ready1", i), f_rdy1, 0);
      tick();
    end
    chk("rr_cnt0", r_c0, 2);
    chk("rr_cnt1", r_c1, 2);
    chk("fx_cnt0", f_c0, 4);
    chk("fx_cnt1", f_c1, 0);

    // port 1 result stalls the slot; port 0 waits until resp_ready1 rises
    rst = 1;
    v0 = 0;
    v1 = 0;
    tick();
    rst = 0;
    rr0 = 1;
    rr1 = 0;
    v1 = 1; op1 = 6; a1 = 64'h8000_0000_0000_0000; b1 = 4;
    #2;
    chk("st_ready1", r_rdy1, 1);
    tick();
    v1 = 0;
    v0 = 1; op0 = 0; a0 = 1; b0 = 2;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("st%0d_ready0", i), {r_rdy0, r_rdy1}, 0);
      chk($sformatf("st%0d_resp_valid", i), {r_rv0, r_rv1}, 2'b01);
      chk($sformatf("st%0d_result", i), r_res, 64'hF800_0000_0000_0000);
      tick();
    end
    rr1 = 1;
    #2;
    chk("st_release_ready0", r_rdy0, 1);
    tick();
    chk("st_next_valid", {r_rv0, r_rv1}, 2'b10);
    chk("st_next_result", r_res, 3);

    // reset while holding a port-0 result
    rr0 = 0;
    v0 = 0;
    tick();
    chk("hr_holding", r_rv0, 1);
    rst = 1;
    v0 = 1;
    #2;
    chk("hr_rst_ready0", r_rdy0, 0);
    tick();
    rst = 0;
    v0 = 0;
    #1;
    chk("hr_resp_valid", {r_rv0, r_rv1}, 0);
    chk("hr_cnt0", r_c0, 0);
    chk("hr_cnt1", r_c1, 0);
    v0 = 1;
    v1 = 1;
    #2;
    chk("hr_tie_ready", {r_rdy0, r_rdy1}, 2'b10);
    tick();
    v0 = 0;
    v1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports req_valid0/req_valid1  input  1  request present on port 0/1.
REQ-005 SHALL have ports req_ready0/req_ready1  output  1  request accepted this cycle.
REQ-006 SHALL have ports req_op0/req_op1  input  4  operation code, same encoding as the team ALU: 0 add, 1 sub, 2 sll, 3 unsigned less-than, 4 xor, 5 srl, 6 sra, 7 or, 8 and.
REQ-007 SHALL have ports req_a0/req_a1 and req_b0/req_b1  input  64  operands 1 and 2.
REQ-008 SHALL have ports resp_valid0/resp_valid1  output  1  result available for port 0/1.
REQ-009 SHALL have ports resp_ready0/resp_ready1  input  1  requester consumes result.
REQ-010 SHALL have port resp_result  output  64  registered result, shared by both ports.
REQ-011 SHALL have port resp_err  output  1  result came from an illegal opcode.
REQ-012 SHALL have ports grant_cnt0/grant_cnt1  output  16  accepted-request counters.

Function
REQ-013 SHALL instantiate exactly one ALU instance; operands and opcode driven from the granted port by a combinational mux.
REQ-014 SHALL implement FSM states IDLE (no result held) and HOLD (result held, awaiting resp_ready of tagged port).
REQ-015 SHALL define "slot free" as state IDLE, or state HOLD with resp_ready of the tagged port high this cycle.
REQ-016 SHALL, when slot free and at least one req_valid high, assert req_ready to exactly one granted port in the same cycle; req_ready combinationally depends on resp_ready.
REQ-017 SHALL, with one valid requester, grant that requester regardless of RR_EN.
REQ-018 SHALL, with both valid and RR_EN=1, grant the port not granted last; last_grant updates only on an accepted request.
REQ-019 SHALL, with both valid and RR_EN=0, always grant port 0.
REQ-020 SHALL, on an accepted request, register the ALU result into resp_result, register the port tag, and enter HOLD next cycle; latency request-accept to resp_valid = 1 cycle.
REQ-021 SHALL assert resp_valid only for the tagged port, and only in HOLD.
REQ-022 SHALL keep resp_result, resp_err and tag stable while HOLD and resp_ready low.
REQ-023 SHALL, in HOLD with resp accepted and no new grant, return to IDLE; with a new grant the same cycle, stay in HOLD with new result (throughput 1 op/cycle).
REQ-024 SHALL treat opcodes 9-15 as illegal: request accepted, resp_result=0, resp_err=1; legal opcodes give resp_err=0.
REQ-025 SHALL compute shifts using operand 2 bits [5:0] only; add/sub wrap modulo 2^64.
REQ-026 SHALL increment grant_cntN on each accepted request of port N, saturating at 16'hFFFF.
REQ-027 SHALL ignore resp_ready of the non-tagged port and all resp_ready in IDLE.

Reset
REQ-028 SHALL, with rst high at a clock edge, set state=IDLE, resp_valid0/1=0, resp_result=0, resp_err=0, last_grant=port 1 (port 0 wins first tie), grant_cnt0/1=0.
REQ-029 SHALL, on reset during HOLD, discard the held result; resp_valid low from the next cycle.
REQ-030 SHALL hold req_ready0/1 low while rst is high.

Verification
REQ-031 SHALL cover: port 0 only, op=0, a=5, b=7, resp_ready0=1 -> req_ready0 cycle 0, resp_valid0=1 cycle 1, resp_result=12, resp_err=0.
REQ-032 SHALL cover: both ports valid continuously, RR_EN=1, resp_ready both 1 -> grants 0,1,0,1 on consecutive cycles; grant_cnt0=grant_cnt1=2 after 4 cycles.
REQ-033 SHALL cover: RR_EN=0, both valid -> port 1 never granted; req_ready1=0 throughout.
REQ-034 SHALL cover: port 1 op=6, a=64'h8000_0000_0000_0000, b=4, resp_ready1 low 3 cycles -> resp_result=64'hF800_0000_0000_0000 held stable, req_ready0/1 low until resp_ready1 rises.
REQ-035 SHALL cover: op=4'hC -> resp_result=0, resp_err=1; then op=1, a=0, b=1 -> resp_result=64'hFFFF_FFFF_FFFF_FFFF, resp_err=0.
REQ-036 SHALL cover: rst asserted one cycle while in HOLD -> resp_valid0/1=0 next cycle, grant_cnt0/1=0, next tie granted to port 0.
